id_ex_stage: RTL and testbench

ID/EX pipeline stage register for the 5-stage RV32 pipelined CPU. It sits directly downstream of the decode-stage Control unit and register file, and captures their outputs for the EX stage. It embeds load-use hazard detection that stalls PC and IF/ID and inserts a bubble. It also honours branch flush and a global memory stall, and keeps a saturating count of load-use bubbles.

---
 rtl/cpu_pkg.sv | 30 +++
 rtl/hazard_detect.sv | 27 ++
 rtl/id_ex_stage.sv | 158 +++++++++++++++
 tb/tb_id_ex_stage.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the RV32 pipeline: opcodes, ALUOp encodings and the
// bundled control word carried through ID/EX.
package cpu_pkg;

  localparam logic [6:0] OPC_R_TYPE = 7'b0110011;
  localparam logic [6:0] OPC_I_ALU  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_SUB = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  localparam logic [1:0] ALUOP_I   = 2'b11;

  // Field order matches the flat {ALUOp, ALUSrc, Branch, MemRead, MemWrite,
  // RegWrite, MemtoReg} concatenation used at the stage boundary.
  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src;
    logic       branch;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection for the ID/EX boundary, plus the PC and IF/ID
// write enables that freeze the front end during a hazard or global stall.
module hazard_detect #(
  parameter int RA_W = 5
) (
  input  logic            mem_read_ex_i,
  input  logic [RA_W-1:0] rd_ex_i,
  input  logic [RA_W-1:0] rs1_id_i,
  input  logic [RA_W-1:0] rs2_id_i,
  input  logic            stall_i,
  output logic            hazard_o,
  output logic            pc_write_o,
  output logic            if_id_write_o
);

  logic rd_nonzero;
  logic rs_match;

  assign rd_nonzero = (rd_ex_i != '0);
  // rs2 is compared regardless of opcode; an occasional needless stall is safe.
  assign rs_match   = (rd_ex_i == rs1_id_i) || (rd_ex_i == rs2_id_i);

  assign hazard_o      = mem_read_ex_i && rd_nonzero && rs_match;
  assign pc_write_o    = ~(hazard_o | stall_i);
  assign if_id_write_o = ~(hazard_o | stall_i);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with embedded load-use bubble insertion, branch
// flush, global stall hold and a saturating count of load-use bubbles.
module id_ex_stage
  import cpu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic [1:0]       ALUOp_i,
  input  logic             ALUSrc_i,
  input  logic             Branch_i,
  input  logic             MemRead_i,
  input  logic             MemWrite_i,
  input  logic             RegWrite_i,
  input  logic             MemtoReg_i,
  input  logic [XLEN-1:0]  pc_i,
  input  logic [XLEN-1:0]  rs1_data_i,
  input  logic [XLEN-1:0]  rs2_data_i,
  input  logic [XLEN-1:0]  imm_i,
  input  logic [9:0]       funct_i,
  input  logic [RA_W-1:0]  rs1_i,
  input  logic [RA_W-1:0]  rs2_i,
  input  logic [RA_W-1:0]  rd_i,
  output logic [1:0]       ALUOp_o,
  output logic             ALUSrc_o,
  output logic             Branch_o,
  output logic             MemRead_o,
  output logic             MemWrite_o,
  output logic             RegWrite_o,
  output logic             MemtoReg_o,
  output logic [XLEN-1:0]  pc_o,
  output logic [XLEN-1:0]  rs1_data_o,
  output logic [XLEN-1:0]  rs2_data_o,
  output logic [XLEN-1:0]  imm_o,
  output logic [9:0]       funct_o,
  output logic [RA_W-1:0]  rs1_o,
  output logic [RA_W-1:0]  rs2_o,
  output logic [RA_W-1:0]  rd_o,
  output logic             hazard_o,
  output logic             pc_write_o,
  output logic             if_id_write_o,
  output logic [CNT_W-1:0] bubble_cnt_o
);

  ctrl_t            ctrl_in;
  ctrl_t            ctrl_q, ctrl_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  rs1_data_q, rs1_data_d;
  logic [XLEN-1:0]  rs2_data_q, rs2_data_d;
  logic [XLEN-1:0]  imm_q, imm_d;
  logic [9:0]       funct_q, funct_d;
  logic [RA_W-1:0]  rs1_q, rs1_d;
  logic [RA_W-1:0]  rs2_q, rs2_d;
  logic [RA_W-1:0]  rd_q, rd_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

  logic hazard;
  logic load_bubble;
  logic count_en;

  assign ctrl_in = {ALUOp_i, ALUSrc_i, Branch_i, MemRead_i,
                    MemWrite_i, RegWrite_i, MemtoReg_i};

  hazard_detect #(
    .RA_W (RA_W)
  ) u_hazard_detect (
    .mem_read_ex_i (ctrl_q.mem_read),
    .rd_ex_i       (rd_q),
    .rs1_id_i      (rs1_i),
    .rs2_id_i      (rs2_i),
    .stall_i       (stall_i),
    .hazard_o      (hazard),
    .pc_write_o    (pc_write_o),
    .if_id_write_o (if_id_write_o)
  );

  assign load_bubble = flush_i | hazard;
  // Only load-use bubbles are counted; a simultaneous flush does not add one.
  assign count_en    = ~stall_i & hazard & ~(&bubble_cnt_q);

  always_comb begin
    ctrl_d       = ctrl_q;
    pc_d         = pc_q;
    rs1_data_d   = rs1_data_q;
    rs2_data_d   = rs2_data_q;
    imm_d        = imm_q;
    funct_d      = funct_q;
    rs1_d        = rs1_q;
    rs2_d        = rs2_q;
    rd_d         = rd_q;
    bubble_cnt_d = bubble_cnt_q;
    if (!stall_i) begin
      // Data fields load in both cases; only control distinguishes a bubble.
      ctrl_d     = load_bubble ? CTRL_NOP : ctrl_in;
      pc_d       = pc_i;
      rs1_data_d = rs1_data_i;
      rs2_data_d = rs2_data_i;
      imm_d      = imm_i;
      funct_d    = funct_i;
      rs1_d      = rs1_i;
      rs2_d      = rs2_i;
      rd_d       = rd_i;
    end
    if (count_en) begin
      bubble_cnt_d = bubble_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ctrl_q       <= CTRL_NOP;
      pc_q         <= '0;
      rs1_data_q   <= '0;
      rs2_data_q   <= '0;
      imm_q        <= '0;
      funct_q      <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      rd_q         <= '0;
      bubble_cnt_q <= '0;
    end else begin
      ctrl_q       <= ctrl_d;
      pc_q         <= pc_d;
      rs1_data_q   <= rs1_data_d;
      rs2_data_q   <= rs2_data_d;
      imm_q        <= imm_d;
      funct_q      <= funct_d;
      rs1_q        <= rs1_d;
      rs2_q        <= rs2_d;
      rd_q         <= rd_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign ALUOp_o      = ctrl_q.alu_op;
  assign ALUSrc_o     = ctrl_q.alu_src;
  assign Branch_o     = ctrl_q.branch;
  assign MemRead_o    = ctrl_q.mem_read;
  assign MemWrite_o   = ctrl_q.mem_write;
  assign RegWrite_o   = ctrl_q.reg_write;
  assign MemtoReg_o   = ctrl_q.mem_to_reg;
  assign pc_o         = pc_q;
  assign rs1_data_o   = rs1_data_q;
  assign rs2_data_o   = rs2_data_q;
  assign imm_o        = imm_q;
  assign funct_o      = funct_q;
  assign rs1_o        = rs1_q;
  assign rs2_o        = rs2_q;
  assign rd_o         = rd_q;
  assign hazard_o     = hazard;
  assign bubble_cnt_o = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage; a second instance with a
// 2-bit counter covers bubble-count saturation.
module tb_id_ex_stage;
  localparam int XLEN = 32;
  localparam int RA_W = 5;
  localparam int DW   = 4 * XLEN + 10 + 3 * RA_W;

  // {ALUOp, ALUSrc, Branch, MemRead, MemWrite, RegWrite, MemtoReg}
  localparam logic [7:0] C_ADD = 8'b10_0_0_0_0_1_0;
  localparam logic [7:0] C_LW  = 8'b00_1_0_1_0_1_1;

  logic clk = 1'b0;
  logic rst_i, stall_i, flush_i;
  logic [1:0] ALUOp_i;
  logic ALUSrc_i, Branch_i, MemRead_i, MemWrite_i, RegWrite_i, MemtoReg_i;
  logic [XLEN-1:0] pc_i, rs1_data_i, rs2_data_i, imm_i;
  logic [9:0] funct_i;
  logic [RA_W-1:0] rs1_i, rs2_i, rd_i;

  logic [1:0] ALUOp_o, ALUOp_s;
  logic ALUSrc_o, Branch_o, MemRead_o, MemWrite_o, RegWrite_o, MemtoReg_o;
  logic ALUSrc_s, Branch_s, MemRead_s, MemWrite_s, RegWrite_s, MemtoReg_s;
  logic [XLEN-1:0] pc_o, rs1_data_o, rs2_data_o, imm_o;
  logic [XLEN-1:0] pc_s, rs1_data_s, rs2_data_s, imm_s;
  logic [9:0] funct_o, funct_s;
  logic [RA_W-1:0] rs1_o, rs2_o, rd_o, rs1_s, rs2_s, rd_s;
  logic hazard_o, pc_write_o, if_id_write_o;
  logic hazard_s, pc_write_s, if_id_write_s;
  logic [15:0] bubble_cnt_o;
  logic [1:0]  bubble_cnt_s;

  logic [7:0]    ctrl_out;
  logic [DW-1:0] data_out;
  assign ctrl_out = {ALUOp_o, ALUSrc_o, Branch_o, MemRead_o, MemWrite_o, RegWrite_o, MemtoReg_o};
  assign data_out = {pc_o, rs1_data_o, rs2_data_o, imm_o, funct_o, rs1_o, rs2_o, rd_o};

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_data;
  logic [15:0]   exp_cnt;
  int n_checks = 0;
  int n_fail   = 0;

  id_ex_stage dut (
    .clk_i(clk), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
    .ALUOp_i(ALUOp_i), .ALUSrc_i(ALUSrc_i), .Branch_i(Branch_i), .MemRead_i(MemRead_i),
    .MemWrite_i(MemWrite_i), .RegWrite_i(RegWrite_i), .MemtoReg_i(MemtoReg_i),
    .pc_i(pc_i), .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .imm_i(imm_i),
    .funct_i(funct_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i),
    .ALUOp_o(ALUOp_o), .ALUSrc_o(ALUSrc_o), .Branch_o(Branch_o), .MemRead_o(MemRead_o),
    .MemWrite_o(MemWrite_o), .RegWrite_o(RegWrite_o), .MemtoReg_o(MemtoReg_o),
    .pc_o(pc_o), .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o), .imm_o(imm_o),
    .funct_o(funct_o), .rs1_o(rs1_o), .rs2_o(rs2_o), .rd_o(rd_o),
    .hazard_o(hazard_o), .pc_write_o(pc_write_o), .if_id_write_o(if_id_write_o),
    .bubble_cnt_o(bubble_cnt_o)
  );

  id_ex_stage #(.CNT_W(2)) dut_sat (
    .clk_i(clk), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i),
    .ALUOp_i(ALUOp_i), .ALUSrc_i(ALUSrc_i), .Branch_i(Branch_i), .MemRead_i(MemRead_i),
    .MemWrite_i(MemWrite_i), .RegWrite_i(RegWrite_i), .MemtoReg_i(MemtoReg_i),
    .pc_i(pc_i), .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .imm_i(imm_i),
    .funct_i(funct_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i),
    .ALUOp_o(ALUOp_s), .ALUSrc_o(ALUSrc_s), .Branch_o(Branch_s), .MemRead_o(MemRead_s),
    .MemWrite_o(MemWrite_s), .RegWrite_o(RegWrite_s), .MemtoReg_o(MemtoReg_s),
    .pc_o(pc_s), .rs1_data_o(rs1_data_s), .rs2_data_o(rs2_data_s), .imm_o(imm_s),
    .funct_o(funct_s), .rs1_o(rs1_s), .rs2_o(rs2_s), .rd_o(rd_s),
    .hazard_o(hazard_s), .pc_write_o(pc_write_s), .if_id_write_o(if_id_write_s),
    .bubble_cnt_o(bubble_cnt_s)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  initial begin
    rst_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
    {ALUOp_i, ALUSrc_i, Branch_i, MemRead_i, MemWrite_i, RegWrite_i, MemtoReg_i} = '0;
    pc_i = '0; rs1_data_i = '0; rs2_data_i = '0; imm_i = '0;
    funct_i = '0; rs1_i = '0; rs2_i = '0; rd_i = '0;
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] ctrl, input logic [RA_W-1:0] rs1,
                       input logic [RA_W-1:0] rs2, input logic [RA_W-1:0] rd,
                       input logic [9:0] funct);
    @(negedge clk);
    {ALUOp_i, ALUSrc_i, Branch_i, MemRead_i, MemWrite_i, RegWrite_i, MemtoReg_i} = ctrl;
    pc_i       = $urandom() & 32'hFFFF_FFFC;
    rs1_data_i = $urandom();
    rs2_data_i = $urandom();
    imm_i      = $urandom();
    funct_i    = funct;
    rs1_i = rs1; rs2_i = rs2; rd_i = rd;
    exp_q.push_back({pc_i, rs1_data_i, rs2_data_i, imm_i, funct, rs1, rs2, rd});
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    {ALUOp_i, ALUSrc_i, Branch_i, MemRead_i, MemWrite_i, RegWrite_i, MemtoReg_i} = 8'($urandom());
    pc_i = $urandom(); rs1_data_i = $urandom(); rs2_data_i = $urandom(); imm_i = $urandom();
    funct_i = 10'($urandom()); rs1_i = 5'($urandom()); rs2_i = 5'($urandom()); rd_i = 5'($urandom());
    rst_i = 1'b1;
    tick();
    n_checks++;
    if (ctrl_out !== 8'h00) begin n_fail++; $display("FAIL reset_ctrl got=%h exp=00", ctrl_out); end
    n_checks++;
    if (data_out !== '0) begin n_fail++; $display("FAIL reset_data got=%h exp=0", data_out); end
    n_checks++;
    if (bubble_cnt_o !== 16'd0) begin n_fail++; $display("FAIL reset_cnt got=%0d exp=0", bubble_cnt_o); end
    n_checks++;
    if (pc_write_o !== 1'b1 || if_id_write_o !== 1'b1 || hazard_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_wr got pcw=%b ifw=%b hz=%b exp=1 1 0", pc_write_o, if_id_write_o, hazard_o);
    end
    rst_i = 1'b0;
    exp_cnt = 16'd0;
  endtask

  task automatic test_pass_through();
    exp_q.delete();
    drive(C_ADD, 5'd1, 5'd2, 5'd3, 10'd0);
    tick();
    exp_data = exp_q.pop_front();
    n_checks++;
    if (ctrl_out !== C_ADD) begin n_fail++; $display("FAIL pass_ctrl got=%h exp=%h", ctrl_out, C_ADD); end
    n_checks++;
    if (data_out !== exp_data) begin n_fail++; $display("FAIL pass_data got=%h exp=%h", data_out, exp_data); end
    n_checks++;
    if (hazard_o !== 1'b0) begin n_fail++; $display("FAIL pass_hazard got=%b exp=0", hazard_o); end
  endtask

  task automatic test_load_use();
    exp_q.delete();
    drive(C_LW, 5'd1, 5'd0, 5'd5, 10'd2);
    tick();
    n_checks++;
    if (MemRead_o !== 1'b1 || rd_o !== 5'd5) begin n_fail++; $display("FAIL lu_lw got mr=%b rd=%0d exp=1 5", MemRead_o, rd_o); end
    drive(C_ADD, 5'd5, 5'd2, 5'd6, 10'd0);
    n_checks++;
    if (hazard_o !== 1'b1 || pc_write_o !== 1'b0 || if_id_write_o !== 1'b0) begin
      n_fail++; $display("FAIL lu_detect got hz=%b pcw=%b ifw=%b exp=1 0 0", hazard_o, pc_write_o, if_id_write_o);
    end
    tick();
    exp_cnt++;
    n_checks++;
    if (ctrl_out !== 8'h00) begin n_fail++; $display("FAIL lu_bubble got=%h exp=00", ctrl_out); end
    n_checks++;
    if (bubble_cnt_o !== exp_cnt) begin n_fail++; $display("FAIL lu_cnt got=%0d exp=%0d", bubble_cnt_o, exp_cnt); end
    n_checks++;
    if (hazard_o !== 1'b0 || pc_write_o !== 1'b1) begin n_fail++; $display("FAIL lu_release got hz=%b pcw=%b exp=0 1", hazard_o, pc_write_o); end
    tick();
    n_checks++;
    if (RegWrite_o !== 1'b1 || rd_o !== 5'd6 || rs1_o !== 5'd5 || ALUOp_o !== 2'b10) begin
      n_fail++; $display("FAIL lu_add got rw=%b rd=%0d rs1=%0d aluop=%b exp=1 6 5 10", RegWrite_o, rd_o, rs1_o, ALUOp_o);
    end
  endtask

  task automatic test_x0_nonmatch();
    drive(C_LW, 5'd1, 5'd2, 5'd0, 10'd2);
    tick();
    drive(C_LW, 5'd0, 5'd0, 5'd5, 10'd2);
    n_checks++;
    if (hazard_o !== 1'b0) begin n_fail++; $display("FAIL x0_hazard got=%b exp=0", hazard_o); end
    tick();
    drive(C_ADD, 5'd6, 5'd7, 5'd8, 10'd0);
    n_checks++;
    if (hazard_o !== 1'b0 || pc_write_o !== 1'b1) begin n_fail++; $display("FAIL nomatch_hazard got hz=%b pcw=%b exp=0 1", hazard_o, pc_write_o); end
    tick();
    n_checks++;
    if (bubble_cnt_o !== exp_cnt || RegWrite_o !== 1'b1 || rd_o !== 5'd8) begin
      n_fail++; $display("FAIL nomatch_pass got cnt=%0d rw=%b rd=%0d exp=%0d 1 8", bubble_cnt_o, RegWrite_o, rd_o, exp_cnt);
    end
  endtask

  task automatic test_flush();
    drive(C_LW, 5'd1, 5'd2, 5'd9, 10'd2);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    n_checks++;
    if (ctrl_out !== 8'h00 || bubble_cnt_o !== exp_cnt) begin
      n_fail++; $display("FAIL flush_only got ctrl=%h cnt=%0d exp=00 %0d", ctrl_out, bubble_cnt_o, exp_cnt);
    end
    drive(C_LW, 5'd1, 5'd2, 5'd4, 10'd2);
    tick();
    drive(C_ADD, 5'd4, 5'd3, 5'd10, 10'd0);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    exp_cnt++;
    n_checks++;
    if (ctrl_out !== 8'h00 || bubble_cnt_o !== exp_cnt) begin
      n_fail++; $display("FAIL flush_hazard got ctrl=%h cnt=%0d exp=00 %0d", ctrl_out, bubble_cnt_o, exp_cnt);
    end
  endtask

  task automatic test_stall();
    logic [7:0] held_ctrl;
    exp_q.delete();
    drive(C_ADD, 5'd1, 5'd2, 5'd10, 10'h100);
    tick();
    exp_data = exp_q.pop_front();
    held_ctrl = C_ADD;
    for (int i = 0; i < 3; i++) begin
      drive(8'($urandom_range(0, 255)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
            5'($urandom_range(0, 31)), 10'($urandom_range(0, 1023)));
      stall_i = 1'b1;
      #1;
      n_checks++;
      if (if_id_write_o !== 1'b0 || pc_write_o !== 1'b0) begin
        n_fail++; $display("FAIL stall_wr cyc=%0d got ifw=%b pcw=%b exp=0 0", i, if_id_write_o, pc_write_o);
      end
      tick();
      n_checks++;
      if (ctrl_out !== held_ctrl || data_out !== exp_data || bubble_cnt_o !== exp_cnt) begin
        n_fail++; $display("FAIL stall_hold cyc=%0d got ctrl=%h cnt=%0d exp=%h %0d", i, ctrl_out, bubble_cnt_o, held_ctrl, exp_cnt);
      end
    end
    stall_i = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_stall_hazard();
    drive(C_LW, 5'd1, 5'd2, 5'd11, 10'd2);
    tick();
    drive(C_ADD, 5'd11, 5'd2, 5'd12, 10'd0);
    stall_i = 1'b1;
    #1;
    n_checks++;
    if (hazard_o !== 1'b1 || pc_write_o !== 1'b0 || if_id_write_o !== 1'b0) begin
      n_fail++; $display("FAIL sh_detect got hz=%b pcw=%b ifw=%b exp=1 0 0", hazard_o, pc_write_o, if_id_write_o);
    end
    tick();
    tick();
    n_checks++;
    if (MemRead_o !== 1'b1 || rd_o !== 5'd11 || bubble_cnt_o !== exp_cnt) begin
      n_fail++; $display("FAIL sh_hold got mr=%b rd=%0d cnt=%0d exp=1 11 %0d", MemRead_o, rd_o, bubble_cnt_o, exp_cnt);
    end
    @(negedge clk);
    stall_i = 1'b0;
    tick();
    exp_cnt++;
    n_checks++;
    if (ctrl_out !== 8'h00 || bubble_cnt_o !== exp_cnt) begin
      n_fail++; $display("FAIL sh_bubble got ctrl=%h cnt=%0d exp=00 %0d", ctrl_out, bubble_cnt_o, exp_cnt);
    end
    tick();
    n_checks++;
    if (RegWrite_o !== 1'b1 || rd_o !== 5'd12) begin n_fail++; $display("FAIL sh_add got rw=%b rd=%0d exp=1 12", RegWrite_o, rd_o); end
  endtask

  task automatic test_reset_mid_hazard();
    drive(C_LW, 5'd1, 5'd2, 5'd12, 10'd2);
    tick();
    drive(C_ADD, 5'd12, 5'd2, 5'd13, 10'd0);
    stall_i = 1'b1;
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    stall_i = 1'b0;
    exp_cnt = 16'd0;
    n_checks++;
    if (ctrl_out !== 8'h00 || pc_o !== '0 || rd_o !== '0 || bubble_cnt_o !== 16'd0 || hazard_o !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid got ctrl=%h pc=%h rd=%0d cnt=%0d hz=%b exp=0", ctrl_out, pc_o, rd_o, bubble_cnt_o, hazard_o);
    end
  endtask

  task automatic test_back_to_back_saturation();
    logic [1:0] exp_sat;
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    exp_cnt = 16'd0;
    exp_sat = 2'd0;
    for (int i = 0; i < 5; i++) begin
      drive(C_LW, 5'd1, 5'd2, 5'd5, 10'd2);
      tick();
      drive(C_ADD, 5'd3, 5'd5, 5'd6, 10'd0);
      tick();
      exp_cnt++;
      if (exp_sat != 2'd3) exp_sat++;
      n_checks++;
      if (bubble_cnt_s !== exp_sat) begin n_fail++; $display("FAIL sat_cnt ev=%0d got=%0d exp=%0d", i, bubble_cnt_s, exp_sat); end
      n_checks++;
      if (bubble_cnt_o !== exp_cnt) begin n_fail++; $display("FAIL wide_cnt ev=%0d got=%0d exp=%0d", i, bubble_cnt_o, exp_cnt); end
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_pass_through();
    test_load_use();
    test_x0_nonmatch();
    test_flush();
    test_stall();
    test_stall_hazard();
    test_reset_mid_hazard();
    test_back_to_back_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
